// File: rtl/ram_master.sv
// Burst controller for an asynchronous single-port SRAM with a shared bidirectional data bus.
// Writes stream at one beat per cycle; reads take a strobe cycle plus a response handshake cycle.
module ram_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        RSP   = 3'd3,
        TURN  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [3:0]              len_reg, len_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0]   rsp_data_reg, rsp_data_next;
    logic                    drive_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            len_reg      <= '0;
            cnt_reg      <= '0;
            rsp_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            len_reg      <= len_next;
            cnt_reg      <= cnt_next;
            rsp_data_reg <= rsp_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        len_next      = len_reg;
        cnt_next      = cnt_reg;
        rsp_data_next = rsp_data_reg;
        req_ready     = 1'b0;
        wr_ready      = 1'b0;
        rsp_valid     = 1'b0;
        mem_cs        = 1'b0;
        mem_we        = 1'b0;
        mem_oe        = 1'b0;
        drive_en      = 1'b0;

        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_next  = req_addr;
                    len_next   = req_len;
                    cnt_next   = '0;
                    state_next = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                // A missing beat is a bubble: nothing strobes and nothing advances.
                mem_cs   = wr_valid;
                mem_we   = wr_valid;
                wr_ready = wr_valid;
                drive_en = wr_valid;
                if (wr_valid) begin
                    addr_next = addr_reg + ADDR_ONE;
                    cnt_next  = cnt_reg + 4'd1;
                    if (cnt_reg == len_reg) begin
                        state_next = IDLE;
                    end
                end
            end
            READ: begin
                // RAM output is valid by the closing edge, so capture it directly.
                mem_cs        = 1'b1;
                mem_oe        = 1'b1;
                rsp_data_next = mem_data;
                state_next    = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (cnt_reg == len_reg) begin
                        state_next = TURN;
                    end else begin
                        addr_next  = addr_reg + ADDR_ONE;
                        cnt_next   = cnt_reg + 4'd1;
                        state_next = READ;
                    end
                end
            end
            TURN: begin
                // Dead cycle so the RAM releases the bus before any write can drive it.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_data = drive_en ? wr_data : {DATA_WIDTH{1'bz}};
    assign mem_addr = addr_reg;
    assign rsp_data = rsp_data_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: a behavioural async SRAM on the shared bus plus
// hand-computed expectations for write/read bursts, stalls, bubbles, wrap and reset abort.
module tb_ram_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [3:0]  req_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [11:0] mem_addr;
    wire  [7:0]  mem_data;
    logic        mem_cs;
    logic        mem_we;
    logic        mem_oe;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    logic [7:0] ram [0:4095];
    logic       ram_drive = 1'b0;
    logic [7:0] vec [16];

    always #5 clk = ~clk;

    ram_master #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .busy      (busy)
    );

    // SRAM model: drives the bus after the mid-cycle falling edge of a read strobe.
    always @(negedge clk) ram_drive <= mem_cs && mem_oe && !mem_we;
    assign mem_data = ram_drive ? ram[mem_addr] : 8'bz;

    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            ram[mem_addr] <= mem_data;
            wr_count      <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [3:0] l, input bit bubble);
        logic [11:0] ea;
        int beat;
        int cyc;
        int start_count;
        start_count = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_len = l;
        #1 check("w_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= int'(l)) begin
            ea = a + 12'(beat);
            if (bubble && (cyc % 2 == 0)) begin
                wr_valid = 1'b0;
                #1;
                check("w_bubble_cs", 32'(mem_cs), 32'h0);
                check("w_bubble_rdy", 32'(wr_ready), 32'h0);
                check("w_bubble_addr", 32'(mem_addr), 32'(ea));
            end else begin
                wr_valid = 1'b1; wr_data = vec[beat];
                #1;
                check("w_cs", 32'(mem_cs), 32'h1);
                check("w_we", 32'(mem_we), 32'h1);
                check("w_oe", 32'(mem_oe), 32'h0);
                check("w_ready", 32'(wr_ready), 32'h1);
                check("w_addr", 32'(mem_addr), 32'(ea));
                beat++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        #1;
        check("w_busy_done", 32'(busy), 32'h0);
        check("w_req_ready_done", 32'(req_ready), 32'h1);
        check("w_count", 32'(wr_count - start_count), 32'(int'(l) + 1));
    endtask

    task automatic do_read(input logic [11:0] a, input logic [3:0] l,
                           input int stall_beat, input int stall_cycles);
        logic [11:0] ea;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = l; rsp_ready = 1'b1;
        #1 check("r_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int beat = 0; beat <= int'(l); beat++) begin
            ea = a + 12'(beat);
            #1;
            check("r_cs", 32'(mem_cs), 32'h1);
            check("r_oe", 32'(mem_oe), 32'h1);
            check("r_we", 32'(mem_we), 32'h0);
            check("r_addr", 32'(mem_addr), 32'(ea));
            check("r_rsp_idle", 32'(rsp_valid), 32'h0);
            @(posedge clk); #1;
            if (beat == stall_beat) begin
                rsp_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    #1;
                    check("r_stall_valid", 32'(rsp_valid), 32'h1);
                    check("r_stall_data", 32'(rsp_data), 32'(vec[beat]));
                    check("r_stall_cs", 32'(mem_cs), 32'h0);
                    @(posedge clk); #1;
                end
                rsp_ready = 1'b1;
            end
            #1;
            check("r_rsp_valid", 32'(rsp_valid), 32'h1);
            check("r_rsp_data", 32'(rsp_data), 32'(vec[beat]));
            check("r_rsp_cs", 32'(mem_cs), 32'h0);
            @(posedge clk); #1;
        end
        #1;
        check("r_turn_busy", 32'(busy), 32'h1);
        check("r_turn_ready", 32'(req_ready), 32'h0);
        check("r_turn_cs", 32'(mem_cs), 32'h0);
        @(posedge clk); #1;
        check("r_idle_ready", 32'(req_ready), 32'h1);
        check("r_idle_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_count;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0;
        #2;
        check("rst_cs", 32'(mem_cs), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_oe", 32'(mem_oe), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rst_req_ready", 32'(req_ready), 32'h1);

        // Continuous 4-beat write, plain readback, then readback with a 5-cycle stall on beat 2
        vec = '{0: 8'hA1, 1: 8'hA2, 2: 8'hA3, 3: 8'hA4, default: 8'h00};
        do_write(12'h010, 4'd3, 1'b0);
        do_read(12'h010, 4'd3, -1, 0);
        do_read(12'h010, 4'd3, 1, 5);

        // Wrap across the top of the address space
        vec = '{0: 8'h5B, 1: 8'h6C, 2: 8'h7D, default: 8'h00};
        do_write(12'hFFF, 4'd2, 1'b0);
        do_read(12'hFFF, 4'd2, -1, 0);

        // Bubbled write with wr_valid low on alternate cycles
        vec = '{0: 8'h31, 1: 8'h32, 2: 8'h33, 3: 8'h34, default: 8'h00};
        do_write(12'h020, 4'd3, 1'b1);
        do_read(12'h020, 4'd3, -1, 0);

        // Pre-fill, then abort an 8-beat write with reset during beat 3
        vec = '{0: 8'h11, 1: 8'h22, 2: 8'h33, 3: 8'h44, default: 8'h00};
        do_write(12'h100, 4'd3, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h100; req_len = 4'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wr_valid = 1'b1; wr_data = 8'hC0;
        @(posedge clk); #1;
        wr_data = 8'hC1;
        @(posedge clk); #1;
        wr_data = 8'hC2;
        #1 check("abort_cs_before", 32'(mem_cs), 32'h1);
        base_count = wr_count;
        rst_n = 1'b0;
        #1;
        check("abort_cs", 32'(mem_cs), 32'h0);
        check("abort_we", 32'(mem_we), 32'h0);
        check("abort_wr_ready", 32'(wr_ready), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_addr", 32'(mem_addr), 32'h0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        check("abort_no_write", 32'(wr_count - base_count), 32'h0);
        wr_valid = 1'b0;
        rst_n = 1'b1;
        #1 check("abort_req_ready", 32'(req_ready), 32'h1);
        vec = '{0: 8'hC0, 1: 8'hC1, 2: 8'h33, 3: 8'h44, default: 8'h00};
        do_read(12'h100, 4'd3, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: width of the memory address.
REQ-002 Parameter DATA_WIDTH, default 8: width of the memory data word.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  burst request present.
REQ-006 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 req_we  input  1  1 = write burst, 0 = read burst.
REQ-008 req_addr  input  ADDR_WIDTH  burst start address.
REQ-009 req_len  input  4  beats minus one (1..16 beats).
REQ-010 wr_valid  input  1  write beat data present.
REQ-011 wr_ready  output  1  write beat consumed this cycle.
REQ-012 wr_data  input  DATA_WIDTH  write beat data.
REQ-013 rsp_valid  output  1  read beat available.
REQ-014 rsp_ready  input  1  read beat consumed when high with rsp_valid.
REQ-015 rsp_data  output  DATA_WIDTH  read beat data.
REQ-016 mem_addr  output  ADDR_WIDTH  RAM address.
REQ-017 mem_data  inout  DATA_WIDTH  shared RAM data bus.
REQ-018 mem_cs, mem_we, mem_oe  output  1 each  RAM chip select, write enable, output enable.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 States SHALL be IDLE, WRITE, READ, RSP, TURN.
REQ-021 req_ready SHALL be high only in IDLE; on req_valid&req_ready, addr, len and we are latched; next state is WRITE if req_we, else READ.
REQ-022 WRITE: mem_cs=wr_valid, mem_we=wr_valid, mem_oe=0, wr_ready=wr_valid, mem_data=wr_data when wr_valid, else high-Z; RAM captures at that posedge.
REQ-023 WRITE with wr_valid low SHALL be a bubble: no strobe, address and beat count unchanged.
REQ-024 Each accepted write beat SHALL increment mem_addr by 1 modulo 2^ADDR_WIDTH and the beat counter by 1; the last beat (count==len) returns to IDLE.
REQ-025 READ: mem_cs=1, mem_oe=1, mem_we=0 for exactly one cycle; the controller SHALL tri-state mem_data and sample it into rsp_data at the closing posedge (RAM drives after the mid-cycle negedge); next state RSP.
REQ-026 RSP: all mem strobes 0, rsp_valid=1, rsp_data stable until rsp_ready; on handshake: if beats remain, mem_addr+1 (wrap) and go to READ; else go to TURN.
REQ-027 TURN: one cycle, strobes 0, bus high-Z, then IDLE; guarantees no write is issued in the cycle after a read drives the bus.
REQ-028 Address wrap: 0xFFF + 1 = 0x000 at ADDR_WIDTH=12; no error flag.
REQ-029 Controller SHALL drive mem_data only when mem_we=1; high-Z in all other states.
REQ-030 mem_addr SHALL be a registered output holding the current beat address.
REQ-031 Read throughput: one beat per 2 cycles minimum; write: one beat per cycle.
REQ-032 req_valid outside IDLE SHALL be ignored and not latched.

Reset
REQ-033 While rst_n=0: state IDLE, mem_cs=mem_we=mem_oe=0, mem_data high-Z, mem_addr=0, rsp_valid=0, rsp_data=0, wr_ready=0, busy=0; req_ready=1 after rst_n deasserts.
REQ-034 Reset mid-burst SHALL abort immediately; no further RAM strobes, remaining beats discarded, pending rsp_valid dropped.

Verification
REQ-035 Write 4 beats at 0x010 (len=3), data 0xA1,0xA2,0xA3,0xA4, wr_valid continuous -> four consecutive mem_cs&mem_we cycles at 0x010..0x013, busy low after 4th.
REQ-036 Read 4 beats at 0x010 with rsp_ready=1 -> rsp_data 0xA1..0xA4 in order, mem_oe pulses each 2 cycles, TURN cycle then req_ready=1.
REQ-037 Read burst with rsp_ready held low 5 cycles on beat 2 -> rsp_valid/rsp_data stable, no mem_cs during stall, data intact.
REQ-038 Write 3 beats at 0xFFF -> writes at 0xFFF, 0x000, 0x001; readback matches.
REQ-039 Write with wr_valid low alternate cycles -> bubbles with mem_cs=0, all 4 beats written once.
REQ-040 rst_n low during 3rd of 8 write beats -> strobes drop same cycle, only 2 addresses modified, outputs at reset values.
